// File: rtl/fifo_capture_pkg.sv
// Shared definitions for the capture-buffer writer: FSM state encoding
// and default geometry of the capture buffer.
package fifo_capture_pkg;

  localparam int DEFAULT_N = 6;
  localparam int DEFAULT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/capture_dpram.sv
// 2^N x W capture storage: synchronous write port, registered read port.
// The array itself is never reset; only the read register clears on rst.
module capture_dpram
  import fifo_capture_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [N-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [N-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem [2**N];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of the array gives the old word on a same-address write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_capture_writer.sv
// Capture writer: arms, fills the buffer up to capture_len (or until stop),
// then reports the last written index to the downstream index counter.
module fifo_capture_writer
  import fifo_capture_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arm,
  input  logic         stop,
  input  logic         din_valid,
  input  logic [W-1:0] din,
  input  logic [N-1:0] capture_len,
  input  logic [N-1:0] rd_index,
  output logic [W-1:0] rd_data,
  output logic [N-1:0] wr_index,
  output logic [N-1:0] maxindex,
  output logic         busy,
  output logic         done,
  output logic         empty,
  output logic         ovf
);

  localparam logic [N-1:0] IDX_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] wr_index_q, wr_index_d;
  logic [N-1:0] maxindex_q, maxindex_d;
  logic         empty_q, empty_d;
  logic         ovf_q, ovf_d;
  logic         wr_en;

  always_comb begin
    state_d    = state_q;
    wr_index_d = wr_index_q;
    maxindex_d = maxindex_q;
    empty_d    = empty_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;

    // arm wins over everything else; any word presented alongside it is dropped
    if (arm) begin
      state_d    = FILL;
      wr_index_d = '0;
      empty_d    = 1'b1;
      ovf_d      = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (din_valid) begin
            wr_en   = 1'b1;
            empty_d = 1'b0;
            if (stop || (wr_index_q == capture_len)) begin
              state_d    = DONE;
              maxindex_d = wr_index_q;
            end else begin
              wr_index_d = wr_index_q + IDX_ONE;
            end
          end else if (stop) begin
            state_d    = DONE;
            maxindex_d = empty_q ? '0 : (wr_index_q - IDX_ONE);
          end
        end
        DONE: begin
          if (din_valid) begin
            ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_index_q <= '0;
      maxindex_q <= '0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_index_q <= wr_index_d;
      maxindex_q <= maxindex_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
    end
  end

  capture_dpram #(
    .N(N),
    .W(W)
  ) u_dpram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_index_q),
    .wr_data(din),
    .rd_addr(rd_index),
    .rd_data(rd_data)
  );

  assign wr_index = wr_index_q;
  assign maxindex = maxindex_q;
  assign busy     = (state_q == FILL);
  assign done     = (state_q == DONE);
  assign empty    = empty_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_fifo_capture_writer.sv
// Directed self-checking bench for fifo_capture_writer at N=6, W=16.
module tb_fifo_capture_writer;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        stop;
  logic        din_valid;
  logic [15:0] din;
  logic [5:0]  capture_len;
  logic [5:0]  rd_index;
  logic [15:0] rd_data;
  logic [5:0]  wr_index;
  logic [5:0]  maxindex;
  logic        busy;
  logic        done;
  logic        empty;
  logic        ovf;

  int checks_total;
  int checks_passed;

  fifo_capture_writer #(
    .N(6),
    .W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .stop       (stop),
    .din_valid  (din_valid),
    .din        (din),
    .capture_len(capture_len),
    .rd_index   (rd_index),
    .rd_data    (rd_data),
    .wr_index   (wr_index),
    .maxindex   (maxindex),
    .busy       (busy),
    .done       (done),
    .empty      (empty),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of inputs, let the rising edge take them, settle 1ns, clear pulses.
  task automatic applyStimulus(input logic a, input logic s, input logic v, input logic [15:0] d);
    arm       = a;
    stop      = s;
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
    arm       = 1'b0;
    stop      = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst         = 1'b1;
    arm         = 1'b0;
    stop        = 1'b0;
    din_valid   = 1'b0;
    din         = 16'h0;
    capture_len = 6'd0;
    rd_index    = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_wr_index", 32'(wr_index), 32'd0);
    checkOutput("reset_maxindex", 32'(maxindex), 32'd0);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    // Full capture of four words
    capture_len = 6'd3;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    checkOutput("full_arm_busy", 32'(busy), 32'd1);
    checkOutput("full_arm_empty", 32'(empty), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'hA0 + i));
    end
    checkOutput("full_done", 32'(done), 32'd1);
    checkOutput("full_busy", 32'(busy), 32'd0);
    checkOutput("full_maxindex", 32'(maxindex), 32'd3);
    checkOutput("full_empty", 32'(empty), 32'd0);
    checkOutput("full_wr_index", 32'(wr_index), 32'd3);
    for (int i = 0; i < 4; i++) begin
      rd_index = 6'(i);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput("full_readback", 32'(rd_data), 32'(16'hA0 + i));
    end

    // Early stop after two words, also exercising read-before-write at address 0
    capture_len = 6'd10;
    rd_index    = 6'd0;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h00B0);
    checkOutput("rbw_old_word", 32'(rd_data), 32'h00A0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h00B1);
    checkOutput("rbw_new_word", 32'(rd_data), 32'h00B0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("stop_maxindex", 32'(maxindex), 32'd1);
    checkOutput("stop_done", 32'(done), 32'd1);
    checkOutput("stop_wr_index", 32'(wr_index), 32'd2);

    // Stop coinciding with the third word keeps that word
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h00C0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h00C1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h00C2);
    checkOutput("stopdv_maxindex", 32'(maxindex), 32'd2);
    checkOutput("stopdv_done", 32'(done), 32'd1);

    // Stop outside FILL changes nothing
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("stop_in_done_state", 32'(done), 32'd1);
    checkOutput("stop_in_done_max", 32'(maxindex), 32'd2);

    // Overflow: data in DONE sets ovf and is not stored
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    checkOutput("ovf_still_done", 32'(done), 32'd1);
    rd_index = 6'd2;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("ovf_buf_addr2", 32'(rd_data), 32'h00C2);
    rd_index = 6'd3;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("ovf_buf_addr3", 32'(rd_data), 32'h00A3);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    checkOutput("rearm_ovf_clear", 32'(ovf), 32'd0);
    checkOutput("rearm_empty", 32'(empty), 32'd1);
    checkOutput("rearm_max_holds", 32'(maxindex), 32'd2);

    // Empty stop
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("empty_done", 32'(done), 32'd1);
    checkOutput("empty_empty", 32'(empty), 32'd1);
    checkOutput("empty_maxindex", 32'(maxindex), 32'd0);

    // Reset in the middle of a fill at wr_index=5
    capture_len = 6'd10;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'hD0 + i));
    end
    checkOutput("pre_rst_wr_index", 32'(wr_index), 32'd5);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_wr_index", 32'(wr_index), 32'd0);
    checkOutput("rst_maxindex", 32'(maxindex), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hEEEE);
    checkOutput("arm_dv_busy", 32'(busy), 32'd1);
    checkOutput("arm_dv_wr_index", 32'(wr_index), 32'd0);
    checkOutput("arm_dv_empty", 32'(empty), 32'd1);
    rd_index = 6'd0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkOutput("arm_dv_not_written", 32'(rd_data), 32'h00D0);

    // Full-depth capture of 64 words
    capture_len = 6'd63;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'(16'h1000 + i));
    end
    checkOutput("deep_wr_index_62", 32'(wr_index), 32'd63);
    checkOutput("deep_still_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h103F);
    checkOutput("deep_done", 32'(done), 32'd1);
    checkOutput("deep_maxindex", 32'(maxindex), 32'd63);
    checkOutput("deep_wr_index", 32'(wr_index), 32'd63);
    rd_index = 6'd63;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("deep_read_63", 32'(rd_data), 32'h103F);
    rd_index = 6'd0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("deep_read_0", 32'(rd_data), 32'h1000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
